// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - AXI4-Stream test-pattern source; optional LFSR pattern under AXIS_PATTERN_GEN_LFSR_EN
module axis_pattern_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int PKT_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [PKT_WIDTH-1:0]  cfg_num_pkts,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [1:0]            cfg_mode,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [PKT_WIDTH-1:0]  pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [PKT_WIDTH-1:0] num_q;
    logic [GAP_WIDTH-1:0] gap_q;
    logic [1:0]           mode_q;
    logic [LEN_WIDTH-1:0] beat_idx;
    logic [31:0]          run_cnt;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic                 stop_pend;

    logic                 accept;
    logic                 run_end;
    logic [LEN_WIDTH-1:0] beat_nxt;
    logic [PKT_WIDTH-1:0] pkt_nxt;

`ifdef AXIS_PATTERN_GEN_LFSR_EN
    logic [31:0] lfsr;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1; taps land on bits 31, 21, 1, 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        lfsr_step = cur[0] ? ((cur >> 1) ^ 32'h8020_0003) : (cur >> 1);
    endfunction
`endif

    assign accept   = m_axis_tvalid & m_axis_tready;
    assign beat_nxt = beat_idx + 1'b1;
    assign pkt_nxt  = pkt_count + 1'b1;
    assign run_end  = stop_pend | stop | ((num_q != '0) && (pkt_nxt == num_q));

    assign m_axis_tkeep = '1;

    // Pattern mux straight off the beat registers, so tdata cannot move while the beat is stalled.
    always_comb begin
        m_axis_tdata = DATA_WIDTH'(beat_idx);
        case (mode_q)
            2'd1: m_axis_tdata = DATA_WIDTH'(run_cnt);
`ifdef AXIS_PATTERN_GEN_LFSR_EN
            2'd2: m_axis_tdata = DATA_WIDTH'({lfsr, lfsr});
`else
            2'd2: m_axis_tdata = DATA_WIDTH'(run_cnt);
`endif
            default: m_axis_tdata = DATA_WIDTH'(beat_idx);
        endcase
    end

    // Run/packet/gap sequencer; all handshake and status outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            len_q         <= '0;
            num_q         <= '0;
            gap_q         <= '0;
            mode_q        <= '0;
            beat_idx      <= '0;
            run_cnt       <= '0;
            gap_cnt       <= '0;
            stop_pend     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pkt_count     <= '0;
`ifdef AXIS_PATTERN_GEN_LFSR_EN
            lfsr          <= 32'h1;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A coincident stop is simply not looked at here, so start wins.
                    if (start && (cfg_len != '0)) begin
                        len_q         <= cfg_len;
                        num_q         <= cfg_num_pkts;
                        gap_q         <= cfg_gap;
                        mode_q        <= cfg_mode;
                        beat_idx      <= '0;
                        run_cnt       <= '0;
                        pkt_count     <= '0;
                        stop_pend     <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (cfg_len == LEN_WIDTH'(1));
                        busy          <= 1'b1;
                        state         <= SEND;
`ifdef AXIS_PATTERN_GEN_LFSR_EN
                        lfsr          <= 32'h1;
`endif
                    end
                end
                SEND: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (accept) begin
                        run_cnt <= run_cnt + 32'd1;
`ifdef AXIS_PATTERN_GEN_LFSR_EN
                        lfsr    <= lfsr_step(lfsr);
`endif
                        if (m_axis_tlast) begin
                            beat_idx  <= '0;
                            pkt_count <= pkt_nxt;
                            if (run_end) begin
                                state         <= IDLE;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                stop_pend     <= 1'b0;
                            end else if (gap_q == '0) begin
                                m_axis_tlast <= (len_q == LEN_WIDTH'(1));
                            end else begin
                                state         <= GAP;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                gap_cnt       <= gap_q;
                            end
                        end else begin
                            beat_idx     <= beat_nxt;
                            m_axis_tlast <= (beat_nxt == (len_q - 1'b1));
                        end
                    end
                end
                GAP: begin
                    // Nothing is in flight during the gap, so a stop can end the run right away.
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        stop_pend <= 1'b0;
                    end else if (gap_cnt == GAP_WIDTH'(1)) begin
                        state         <= SEND;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (len_q == LEN_WIDTH'(1));
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb/tb_axis_pattern_gen.sv - scoreboard bench for axis_pattern_gen
module tb_axis_pattern_gen;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int LW = 16;
    localparam int PW = 16;
    localparam int GW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          lst;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [LW-1:0] cfg_len;
    logic [PW-1:0] cfg_num_pkts;
    logic [GW-1:0] cfg_gap;
    logic [1:0]    cfg_mode;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic [PW-1:0] pkt_count;

    axis_pattern_gen #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .PKT_WIDTH(PW), .GAP_WIDTH(GW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_len(cfg_len), .cfg_num_pkts(cfg_num_pkts), .cfg_gap(cfg_gap), .cfg_mode(cfg_mode),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    int    cyc = 0;
    int    last_cyc = 0;
    int    acc_cnt = 0;
    int    done_cnt = 0;
    int    low_cnt = 0;
    bit    seen_last = 1'b0;
    bit    chk_gap = 1'b0;
    int    exp_gap = 0;
    bit    rand_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_run(input int len, input int npkts, input int mode);
        beat_t b;
        int    rc;
        rc = 0;
        for (int p = 0; p < npkts; p++) begin
            for (int i = 0; i < len; i++) begin
                b.data = (mode == 1 || mode == 2) ? DW'(rc) : DW'(i);
                b.lst  = (i == len - 1);
                exp_q.push_back(b);
                rc++;
            end
        end
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.lst  = l;
        exp_q.push_back(b);
    endtask

    // Ready driver: either held high or toggled at random, always changed just after the edge.
    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitor: every presented beat must match the queue head, stalled or not.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!rst) begin
            if (done) begin
                done_cnt++;
                check_eq("done_latency", 64'(cyc - last_cyc), 64'(1));
            end
            if (m_axis_tvalid) begin
                if (chk_gap && seen_last) begin
                    check_eq("gap_cycles", 64'(low_cnt), 64'(exp_gap));
                end
                seen_last = 1'b0;
                low_cnt   = 0;
                check_eq("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check_eq("tdata", 64'(m_axis_tdata), 64'(e.data));
                    check_eq("tlast", 64'(m_axis_tlast), 64'(e.lst));
                    if (m_axis_tready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                        if (e.lst) begin
                            seen_last = 1'b1;
                            last_cyc  = cyc;
                        end
                    end
                end
            end else if (busy) begin
                low_cnt++;
            end
        end
    end

    task automatic run_start(input int len, input int npkts, input int gap, input int mode, input bit with_stop);
        @(posedge clk);
        #1;
        cfg_len      = LW'(len);
        cfg_num_pkts = PW'(npkts);
        cfg_gap      = GW'(gap);
        cfg_mode     = 2'(mode);
        start        = 1'b1;
        stop         = with_stop;
        seen_last    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check_eq("first_beat_latency", 64'(m_axis_tvalid), 64'(1));
    endtask

    task automatic wait_done(input int exp_pkts);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("done_seen", 64'(got), 64'(1));
        #1;
        check_eq("pkt_count", 64'(pkt_count), 64'(exp_pkts));
        check_eq("queue_drained", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 64'(done), 64'(0));
        check_eq("busy_after_done", 64'(busy), 64'(0));
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_accepted(input int target);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (acc_cnt >= target) begin
                break;
            end
        end
        check_eq("beats_reached", 64'(acc_cnt >= target), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dn;
        rst          = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        cfg_len      = '0;
        cfg_num_pkts = '0;
        cfg_gap      = '0;
        cfg_mode     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check_eq("rst_tlast", 64'(m_axis_tlast), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_tdata", 64'(m_axis_tdata), 64'(0));
        check_eq("rst_pkt_count", 64'(pkt_count), 64'(0));
        check_eq("tkeep_ones", 64'(m_axis_tkeep), 64'({KW{1'b1}}));
        rst = 1'b0;

        // Basic back-to-back run: 0,1,2,3,0,1,2,3 with no idle cycle between packets.
        chk_gap = 1'b1;
        exp_gap = 0;
        push_run(4, 2, 0);
        run_start(4, 2, 0, 0, 1'b0);
        wait_done(2);
        chk_gap = 1'b0;

        // Random backpressure, running counter across two packets.
        push_run(8, 2, 1);
        rand_ready = 1'b1;
        run_start(8, 2, 3, 1, 1'b0);
        wait_done(2);
        rand_ready = 1'b0;

        // Gap of 5 idle cycles, counter continuous across packets.
        chk_gap = 1'b1;
        exp_gap = 5;
        push_run(2, 3, 1);
        run_start(2, 3, 5, 1, 1'b0);
        wait_done(3);
        chk_gap = 1'b0;

        // Continuous run stopped on beat 5 of packet 3; cfg change mid-run must not matter.
        push_run(16, 3, 0);
        base = acc_cnt;
        run_start(16, 0, 0, 0, 1'b0);
        cfg_len  = LW'(2);
        cfg_mode = 2'd1;
        wait_accepted(base + 36);
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_done(3);

        // Zero length start is ignored.
        dn = done_cnt;
        @(posedge clk);
        #1;
        cfg_len = '0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("len0_busy", 64'(busy), 64'(0));
        check_eq("len0_tvalid", 64'(m_axis_tvalid), 64'(0));
        check_eq("len0_no_done", 64'(done_cnt), 64'(dn));

        // len = 1 with stop in the start cycle: start wins, all three packets appear.
        push_run(1, 3, 0);
        run_start(1, 3, 0, 0, 1'b1);
        wait_done(3);

        // Reserved mode 3 behaves as per-packet index.
        push_run(3, 1, 0);
        run_start(3, 1, 2, 3, 1'b0);
        wait_done(1);

        // Mode 2: LFSR when enabled, otherwise running counter.
`ifdef AXIS_PATTERN_GEN_LFSR_EN
        push_beat(DW'(32'h0000_0001), 1'b0);
        push_beat(DW'(32'h8020_0003), 1'b0);
        push_beat(DW'(32'hC030_0002), 1'b0);
        push_beat(DW'(32'h6018_0001), 1'b1);
`else
        push_run(4, 1, 2);
`endif
        run_start(4, 1, 0, 2, 1'b0);
        wait_done(1);

        // Asynchronous reset while beat 3 is on the bus.
        push_run(8, 1, 0);
        base = acc_cnt;
        dn   = done_cnt;
        run_start(8, 0, 0, 0, 1'b0);
        wait_accepted(base + 2);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check_eq("async_rst_busy", 64'(busy), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_abort_no_done", 64'(done_cnt), 64'(dn));
        check_eq("rst_abort_pkt_count", 64'(pkt_count), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
